// File: rtl/key_event_fifo.sv
// Key event FIFO: buffers keys from the PS/2 decoder for the processor.
// The decoder's strobe is brought into the sysclk domain. Each falling edge
// of that strobe queues one ASCII code. The oldest key is shown on
// key_reg/sample, and each key stays there until the processor pops it.
module key_event_fifo #(
   parameter int         DEPTH     = 16,
   parameter int         PTR_W     = 4,
   parameter logic [7:0] RESET_KEY = 8'd49
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic [7:0]       ascii_code,
   input  logic             scan_code_ready,
   input  logic             pop,
   input  logic             clear_ovf,
   output logic [7:0]       key_reg,
   output logic             sample,
   output logic             key_valid,
   output logic             irq,
   output logic [PTR_W:0]   count,
   output logic             overflow
);

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_sync3;
   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;
   logic [7:0]       r_keyReg;
   logic             r_sample;
   logic             r_keyValid;
   logic             r_overflow;

   logic             w_pushEvt;
   logic             w_full;
   logic             w_empty;
   logic             w_xfer;
   logic             w_pushAccept;
   logic             w_pushDrop;
   logic             w_popInvalidate;

   // A falling edge of the synchronised strobe is seen as s3 high and s2 low.
   // This pulse lasts exactly one cycle.
   assign w_pushEvt       = r_sync3 & ~r_sync2;
   assign w_full          = (r_count == FULL_COUNT);
   assign w_empty         = (r_count == '0);
   // Storage feeds the output register whenever it holds a key and the
   // output register is either free or being consumed this cycle.
   assign w_xfer          = ~w_empty & (~r_keyValid | pop);
   // A transfer in the same cycle frees one slot, so a push into a full
   // FIFO can still be accepted.
   assign w_pushAccept    = w_pushEvt & (~w_full | w_xfer);
   assign w_pushDrop      = w_pushEvt & w_full & ~w_xfer;
   assign w_popInvalidate = pop & r_keyValid & w_empty;

   // Two-flop synchroniser plus history flop; idles high like the decoder strobe
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
      end else begin
         r_sync1 <= scan_code_ready;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   // Key storage; contents need no reset because the pointers define validity
   always_ff @(posedge sysclk) begin
      if (rst_n && w_pushAccept) begin
         r_mem[r_wrPtr] <= ascii_code;
      end
   end

   // Read/write pointers and occupancy count
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushAccept) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_xfer) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_pushAccept, w_xfer})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Output register: load the head key on transfer, and drop validity when
   // the last key is popped
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_keyReg   <= RESET_KEY;
         r_sample   <= 1'b1;
         r_keyValid <= 1'b0;
      end else if (w_xfer) begin
         r_keyReg   <= r_mem[r_rdPtr];
         r_sample   <= ~r_sample;
         r_keyValid <= 1'b1;
      end else if (w_popInvalidate) begin
         r_keyValid <= 1'b0;
      end
   end

   // Sticky overflow flag; a drop in the same cycle as a clear keeps it set
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
      end else if (w_pushDrop) begin
         r_overflow <= 1'b1;
      end else if (clear_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign key_reg   = r_keyReg;
   assign sample    = r_sample;
   assign key_valid = r_keyValid;
   assign irq       = r_keyValid;
   assign count     = r_count;
   assign overflow  = r_overflow;

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Buffers keyboard events between the PS/2 keyboard decoder and the processor datapath's memory-mapped key interface.
- Synchronises the decoder's `scan_code_ready` strobe into the `sysclk` domain and queues the ASCII codes in a FIFO, so bursts of keystrokes are not lost while the processor is busy.
- Presents the oldest key on the existing `key_reg`/`sample`-toggle interface.
- Frees each entry only on an explicit processor `pop`, and raises a level interrupt request while a key is pending.

Parameters:
- DEPTH, 16, storage entries excluding the output register; power of 2, range 2..256.
- PTR_W, 4, pointer width; equals log2(DEPTH).
- RESET_KEY, 8'd49, value of `key_reg` after reset.

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- ascii_code  in  8  decoded key from keyboard decoder; stable while scan_code_ready is low
- scan_code_ready  in  1  decoder strobe, asynchronous to sysclk; a falling edge marks a new key
- pop  in  1  single-cycle consume pulse from processor/memory side
- clear_ovf  in  1  clears the overflow flag
- key_reg  out  8  current head key
- sample  out  1  toggles each time key_reg is loaded with a new entry
- key_valid  out  1  key_reg holds an unconsumed key
- irq  out  1  interrupt request; equals key_valid
- count  out  PTR_W+1  entries in storage, 0..DEPTH (output register not counted)
- overflow  out  1  sticky flag: a key was dropped

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - key_reg=RESET_KEY, sample=1, key_valid=0, irq=0, count=0, overflow=0.
  - Pointers=0; synchroniser flops=1 (idle high).
  - Reset dominates every other input in that cycle; a reset mid-burst discards all queued keys and any in-flight edge.
- Synchroniser:
  - Two flops s1→s2, then a history flop s3.
  - push_evt = s3 & ~s2 (falling edge), one cycle wide per falling edge.
  - Input fall sampled at edge k gives push_evt high in the cycle after edge k+1; the push happens at edge k+2.
- Push:
  - On push_evt, ascii_code is sampled at the push edge.
  - If count<DEPTH, or a storage→output transfer occurs in the same cycle: write mem[wr_ptr], increment wr_ptr (wraps modulo DEPTH).
  - Otherwise drop the key and set overflow=1.
- Output stage: a transfer loads key_reg from mem[rd_ptr], increments rd_ptr (wraps), toggles sample, and sets key_valid=1. A transfer occurs when count>0 and either:
  - key_valid=0, or
  - pop=1 with key_valid=1.
- Pop:
  - pop with key_valid=1 and count=0: key_valid←0; key_reg and sample hold their last values.
  - pop with key_valid=0 is ignored and has no side effects.
- Latency:
  - Empty FIFO and key_valid=0: key_reg/sample update at edge k+3 (4th rising edge counting the sampling edge).
  - No same-cycle bypass from push to output.
- Count:
  - +1 on accepted push, −1 on transfer; both in one cycle → unchanged.
  - Never exceeds DEPTH; never underflows.
- Simultaneous push and pop when full (count=DEPTH, key_valid=1): the transfer frees a slot and the push is accepted; count stays DEPTH and overflow is unchanged.
- Overflow:
  - clear_ovf=1 clears the flag.
  - If a drop and clear_ovf occur in the same cycle, set wins (overflow=1).
- irq is combinationally equal to registered key_valid; no glitching.
- Ordering: keys exit strictly in arrival order; each stored key causes exactly one sample toggle.

Test Plan:
- Reset then idle, scan_code_ready held high → key_reg=49, sample=1, key_valid=0, count=0, irq=0 for 20 cycles.
- Single key: ascii_code=0x41, scan_code_ready falls at edge 10 → key_reg=0x41, sample=0, key_valid=1 at edge 13; pop at edge 20 → key_valid=0, key_reg stays 0x41.
- Burst without pop: 5 keys 0x30..0x34, spaced 10 cycles apart → key_reg=0x30 and count=4. Then pop 5 times → key_reg steps 0x31..0x34, sample toggles 4 more times, final key_valid=0.
- Overflow: 18 keys (0x50..0x61) with no pop, DEPTH=16 → key_reg=0x50, count=16, key 0x61 dropped, overflow=1. Draining yields 0x51..0x60; clear_ovf → overflow=0.
- Full plus simultaneous event: with count=16, align a push edge with pop → new key accepted, count=16, overflow stays 0, ordering intact.
- Reset mid-operation: count=7 and key_valid=1, rst_n low for one edge → all outputs return to reset values. A falling edge already inside the synchroniser produces no push after reset.
